// File: rtl/apb_mem_pkg.sv
// Shared types and sizing helpers for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

  // Byte-offset bits inside one word; zero for byte-wide memories.
  function automatic int off_w(input int dw);
    return (dw > 8) ? $clog2(dw / 8) : 0;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DW storage: one synchronous byte-enabled write port, one asynchronous read port.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [IW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [IW-1:0]     raddr,
  output logic [DW-1:0]     rdata
);

  localparam int NBYTES = nbytes(DW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave with word memory, programmable wait states and error response.
// Build option: APB_MEM_STRB_EN honours PSTRB per byte lane; otherwise writes update every lane.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 12,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [AW-1:0]     PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DW-1:0]     PWDATA,
  input  logic [DW/8-1:0]   PSTRB,
  output logic [DW-1:0]     PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int NBYTES = nbytes(DW);
  localparam int OFF_W  = off_w(DW);
  localparam int IW     = idx_w(DEPTH);
  localparam logic [AW-1:0] OFF_MASK = AW'(NBYTES - 1);

  apb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_p0;
  logic [IW-1:0]     idx_p0;

  logic [AW-1:0]     word_idx;
  logic              addr_err;
  logic              setup_go;
  logic              wr_en;
  logic [NBYTES-1:0] lane_en;
  logic [DW-1:0]     rd_word;

  // Address decode for the transfer currently on the bus
  assign word_idx = PADDR >> OFF_W;
  assign addr_err = (64'(word_idx) >= 64'(DEPTH)) || ((PADDR & OFF_MASK) != '0);
  assign setup_go = (state_q == IDLE) && PSEL && !PENABLE;

  assign PREADY  = (state_q == ACCESS) && PENABLE && (cnt_q == '0);
  assign PSLVERR = PREADY && err_p0;

  // A reset landing on the completion edge still wins over the write.
  assign wr_en = PSEL && PENABLE && PREADY && PWRITE && !err_p0 && !PRESET;

`ifdef APB_MEM_STRB_EN
  assign lane_en = PSTRB;
`else
  // Strobes are ignored in this build; the OR keeps the port read.
  assign lane_en = PSTRB | {NBYTES{1'b1}};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = ACCESS;
      ACCESS: begin
        if (!PSEL)                   state_d = IDLE;
        else if (PENABLE && PREADY)  state_d = IDLE;
      end
      default:                       state_d = IDLE;
    endcase
  end

  // Setup edge: capture control for the access phase
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (setup_go) begin
        cnt_q  <= CNT_W'(WAIT_STATES);
        err_p0 <= addr_err;
      end else if ((state_q == ACCESS) && PENABLE && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (setup_go) idx_p0 <= word_idx[IW-1:0];
  end

  // Read data is fetched at setup and held through the access phase
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA <= '0;
    end else if (setup_go && !PWRITE) begin
      PRDATA <= addr_err ? '0 : rd_word;
    end
  end

  apb_mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (PCLK),
    .we    (wr_en),
    .be    (lane_en),
    .waddr (idx_p0),
    .wdata (PWDATA),
    .raddr (word_idx[IW-1:0]),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized bench for apb_mem_slave against a word-array reference model.
module tb_apb_mem_slave;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] prd_exp;

  apb_mem_slave #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) u_dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    logic [3:0] eff;
`ifdef APB_MEM_STRB_EN
    eff = strb;
`else
    eff = 4'hF;
`endif
    for (int b = 0; b < 4; b++)
      if (eff[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  // Called just after a clock edge; returns just after the final edge of the transfer.
  task automatic apb_xfer(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int abort_at, input int rst_at);
    bit err;
    bit stop;
    int idx;
    err  = (int'(addr) >= DEPTH * 4) || (addr[1:0] != 2'b00);
    idx  = int'(addr) / 4;
    stop = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(negedge PCLK);
    check_val("setup_pready", PREADY, 0);
    check_val("setup_prdata", PRDATA, prd_exp);
    @(posedge PCLK);
    if (!wr) prd_exp = err ? 32'h0 : mdl[idx];
    #1;
    for (int k = 0; k <= WS && !stop; k++) begin
      if (k == abort_at) begin
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check_val("abort_pready", PREADY, 0);
        check_val("abort_prdata", PRDATA, prd_exp);
        @(posedge PCLK); #1;
        stop = 1'b1;
      end else begin
        PENABLE = 1'b1;
        if (k == rst_at) PRESET = 1'b1;
        @(negedge PCLK);
        check_val("acc_pready", PREADY, (k == WS));
        check_val("acc_pslverr", PSLVERR, (k == WS) && err);
        check_val("acc_prdata", PRDATA, prd_exp);
        @(posedge PCLK);
        if (k == rst_at) begin
          prd_exp = 32'h0;
          #1 PRESET = 1'b0;
          @(negedge PCLK);
          check_val("rst_pready", PREADY, 0);
          check_val("rst_pslverr", PSLVERR, 0);
          check_val("rst_prdata", PRDATA, prd_exp);
          @(posedge PCLK); #1;
          PSEL = 1'b0; PENABLE = 1'b0;
          stop = 1'b1;
        end else begin
          if (k == WS && wr && !err) model_write(idx, data, strb);
          #1;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_val("idle_pready", PREADY, 0);
    @(posedge PCLK); #1;
  endtask

  task automatic protocol_violation();
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = AW'($urandom_range(0, DEPTH - 1) * 4); PWDATA = $urandom; PSTRB = 4'hF;
    @(negedge PCLK);
    check_val("viol_pready", PREADY, 0);
    check_val("viol_pslverr", PSLVERR, 0);
    check_val("viol_prdata", PRDATA, prd_exp);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) apb_xfer(1'b0, AW'(i * 4), 32'h0, 4'h0, -1, -1);
  endtask

  initial begin
    logic [AW-1:0] addr;
    logic [31:0]   exp_word;
    int            sel, abort_at, rst_at;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    prd_exp = 32'h0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check_val("reset_pready", PREADY, 0);
    check_val("reset_pslverr", PSLVERR, 0);
    check_val("reset_prdata", PRDATA, 32'h0);
    @(posedge PCLK); #1;

    for (int i = 0; i < DEPTH; i++) apb_xfer(1'b1, AW'(i * 4), $urandom, 4'hF, -1, -1);

    apb_xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, -1, -1);
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, -1, -1);
    check_val("deadbeef_readback", PRDATA, 32'hDEADBEEF);

    apb_xfer(1'b1, 12'h00C, 32'h11223344, 4'hF, -1, -1);
    apb_xfer(1'b1, 12'h00C, 32'hAABBCCDD, 4'b0101, -1, -1);
    apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, -1, -1);
`ifdef APB_MEM_STRB_EN
    exp_word = 32'h11BB33DD;
`else
    exp_word = 32'hAABBCCDD;
`endif
    check_val("strobe_readback", PRDATA, exp_word);

    apb_xfer(1'b1, 12'h040, 32'hCAFEF00D, 4'hF, -1, -1);
    apb_xfer(1'b1, 12'h002, 32'hCAFEF00D, 4'hF, -1, -1);
    read_all();
    apb_xfer(1'b0, 12'h040, 32'h0, 4'h0, -1, -1);
    check_val("oob_read_prdata", PRDATA, 32'h0);

    exp_word = mdl[4];
    apb_xfer(1'b1, 12'h010, 32'h5A5A5A5A, 4'hF, -1, 1);
    apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, -1, -1);
    check_val("reset_abort_readback", PRDATA, exp_word);

    apb_xfer(1'b1, 12'h000, 32'h01234567, 4'hF, -1, -1);
    apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, -1, -1);
    check_val("b2b_readback", PRDATA, 32'h01234567);
    apb_xfer(1'b1, 12'h03C, 32'h89ABCDEF, 4'hF, -1, -1);

    apb_xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'h0, -1, -1);
    apb_xfer(1'b1, 12'h014, 32'h13579BDF, 4'hF, 0, -1);
    apb_xfer(1'b1, 12'h018, 32'h2468ACE0, 4'hF, WS, -1);
    protocol_violation();
    read_all();

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 8) begin
        idle_cycle();
      end else if (sel < 12) begin
        protocol_violation();
      end else begin
        sel = $urandom_range(0, 9);
        if (sel < 7)      addr = AW'($urandom_range(0, DEPTH - 1) * 4);
        else if (sel < 9) addr = AW'($urandom_range(0, 4095));
        else              addr = AW'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WS)) : -1;
        rst_at   = (abort_at < 0 && $urandom_range(0, 24) == 0) ? int'($urandom_range(0, WS - 1)) : -1;
        apb_xfer(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), abort_at, rst_at);
      end
    end
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits, a multiple of 8 in the range 8..64.
REQ-002 SHALL have parameter AW, default 12, meaning PADDR width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of DW-bit words of storage, with DEPTH <= 2**(AW-log2(DW/8)).
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning access-phase wait cycles inserted before PREADY, in the range 0..15.
REQ-005 SHALL have port PCLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port PRESET, input, 1 bit, reset that is synchronous and active-high.
REQ-007 SHALL have port PADDR, input, AW bits, byte address.
REQ-008 SHALL have ports PSEL, PENABLE and PWRITE, each input, 1 bit, APB select, enable and direction (1 = write).
REQ-009 SHALL have port PWDATA, input, DW bits, write data.
REQ-010 SHALL have port PSTRB, input, DW/8 bits, byte-lane write strobes.
REQ-011 SHALL have port PRDATA, output, DW bits, registered read data.
REQ-012 SHALL have port PREADY, output, 1 bit, transfer complete.
REQ-013 SHALL have port PSLVERR, output, 1 bit, error response, qualified by PREADY.

Function
REQ-014 SHALL decode word index = PADDR >> log2(DW/8), and treat a transfer as errored when index >= DEPTH or PADDR[log2(DW/8)-1:0] != 0.
REQ-015 SHALL implement FSM states IDLE and ACCESS.
- IDLE -> ACCESS on PSEL & !PENABLE (setup cycle).
- ACCESS -> IDLE on PSEL & PENABLE & PREADY.
- ACCESS -> IDLE whenever PSEL = 0 (aborted transfer; no write, no error).
REQ-016 SHALL load the wait counter with WAIT_STATES on the setup edge, and decrement it on each ACCESS cycle with PENABLE = 1 while it is nonzero.
REQ-017 SHALL drive PREADY = (state == ACCESS) & PENABLE & (counter == 0), combinationally from registered state; PREADY is 0 otherwise.
REQ-018 SHALL, for a non-errored read, register mem[index] into PRDATA on the setup edge, giving data valid from the first access cycle and held until the next setup edge.
REQ-019 SHALL load PRDATA with 0 on the setup edge of an errored read; PRDATA is unchanged by writes.
REQ-020 SHALL commit a write only on the edge where PSEL & PENABLE & PREADY & PWRITE & !error, updating only the enabled byte lanes.
REQ-021 SHALL drive PSLVERR = PREADY & error, where error is latched at setup; an errored write leaves the memory unchanged.
REQ-022 SHALL accept back-to-back transfers: the cycle after completion may be a new setup cycle, with no dead cycle required.
REQ-023 SHALL ignore PSTRB on reads, and on a write with PSTRB = 0 complete normally with no memory change.
REQ-024 SHALL, when PSEL is high with PENABLE high while in IDLE (protocol violation), stay in IDLE with PREADY = 0 and no memory access.

Reset
REQ-025 SHALL, on PRESET = 1 at a PCLK edge, set the state to IDLE, the counter to 0 and PRDATA to 0, giving PREADY = 0 and PSLVERR = 0.
REQ-026 SHALL leave memory contents unreset; a reset asserted mid-transfer SHALL abort that transfer with no write committed.

Configuration
REQ-027 SHALL, with macro APB_MEM_STRB_EN defined, honour PSTRB per byte lane as in REQ-020.
REQ-028 SHALL, with APB_MEM_STRB_EN undefined, keep the PSTRB port present but ignore it, so that every committed write updates all DW/8 lanes.

Structure
REQ-029 SHALL place in package apb_mem_pkg: the FSM state typedef (IDLE, ACCESS), the NBYTES = DW/8 and word-offset width helper constants, and the WAIT_STATES maximum constant.
REQ-030 SHALL implement storage in sub-module apb_mem_array (DEPTH x DW, one synchronous write port with byte enables, one read port); the FSM, counter and error decode reside in apb_mem_slave.

Verification
REQ-031 SHALL cover: WAIT_STATES=0, write 0xDEADBEEF to 0x004 then read 0x004 -> write completes in the first access cycle, read PRDATA = 0xDEADBEEF, PSLVERR = 0.
REQ-032 SHALL cover: WAIT_STATES=3, read 0x008 -> PREADY low for 3 access cycles and high on the 4th, PRDATA stable throughout.
REQ-033 SHALL cover: APB_MEM_STRB_EN defined, word at 0x00C = 0x11223344, write 0xAABBCCDD with PSTRB = 4'b0101 -> readback 0x11BB33DD; with the macro undefined -> readback 0xAABBCCDD.
REQ-034 SHALL cover: DEPTH=16, write to 0x040 and to 0x002 -> PSLVERR = 1 with PREADY, all 16 words unchanged; read 0x040 -> PRDATA = 0, PSLVERR = 1.
REQ-035 SHALL cover: WAIT_STATES=2, PRESET asserted in the 2nd access cycle of a write to 0x010 -> PREADY = 0, PRDATA = 0, readback of 0x010 still shows the old value.
REQ-036 SHALL cover: back-to-back write 0x000 / read 0x000 / write 0x3C with no idle cycles -> all three complete, and the read returns the first write's data.
